pcileech_cpl_tx_engine: RTL and testbench

//  Transmit side of the PCIe TLP path: turns accepted memory-read requests into

---
 rtl/pcileech_tlp_pkg.sv | 27 ++
 rtl/pcileech_cpl_tx_engine_if.sv | 48 ++++
 rtl/pcileech_cpl_hdr_builder.sv | 34 +++
 rtl/pcileech_cpl_tx_engine.sv | 156 +++++++++++++++
 tb/tb_pcileech_cpl_tx_engine.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pcileech_tlp_pkg.sv
// Shared TLP encodings and FSM state type for the completion transmit path.
package pcileech_tlp_pkg;

    localparam logic [7:0] FMT_TYPE_CPLD = 8'h4A;
    localparam logic [7:0] FMT_TYPE_CPL  = 8'h0A;

    typedef enum logic [2:0] {
        SC = 3'b000,
        UR = 3'b001
    } cpl_status_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_HDR2,
        ST_FETCH,
        ST_WAIT,
        ST_SEND
    } cpl_tx_state_t;

    // A length field of zero encodes the maximum of 1024 DW.
    function automatic logic [10:0] len_to_dw(input logic [9:0] len);
        return (len == 10'd0) ? 11'd1024 : {1'b0, len};
    endfunction

endpackage

// File: rtl/pcileech_cpl_tx_engine_if.sv
// Request, BAR read port and TX stream bundle between the completion engine and its neighbours.
interface pcileech_cpl_tx_engine_if;
    import pcileech_tlp_pkg::*;

    // Every valid/ready pair transfers on a rising edge where both are high; the
    // source holds payload and valid stable until that edge, and may not retract valid.
    logic          req_valid;
    logic          req_ready;
    logic [15:0]   req_requester_id;
    logic [7:0]    req_tag;
    logic [2:0]    req_tc;
    logic [1:0]    req_attr;
    logic [9:0]    req_length;
    logic [31:0]   req_addr;

    logic          bar_rd_en;
    logic [31:0]   bar_addr;
    logic [31:0]   bar_rd_data;
    logic          bar_rd_valid;

    logic [31:0]   pcie_tx_data;
    logic          pcie_tx_valid;
    logic          pcie_tx_last;
    logic          pcie_tx_ready;

    cpl_tx_state_t dbg_state;

    modport master (
        input  req_valid, req_requester_id, req_tag, req_tc, req_attr, req_length, req_addr,
        output req_ready,
        output bar_rd_en, bar_addr,
        input  bar_rd_data, bar_rd_valid,
        output pcie_tx_data, pcie_tx_valid, pcie_tx_last,
        input  pcie_tx_ready,
        output dbg_state
    );

    modport slave (
        output req_valid, req_requester_id, req_tag, req_tc, req_attr, req_length, req_addr,
        input  req_ready,
        input  bar_rd_en, bar_addr,
        output bar_rd_data, bar_rd_valid,
        input  pcie_tx_data, pcie_tx_valid, pcie_tx_last,
        output pcie_tx_ready,
        input  dbg_state
    );

endinterface

// File: rtl/pcileech_cpl_hdr_builder.sv
// Combinational 3DW completion header formatter; UR completions carry no data and zero length/byte count.
module pcileech_cpl_hdr_builder
    import pcileech_tlp_pkg::*;
(
    input  logic [15:0] i_completer_id,
    input  logic [15:0] i_requester_id,
    input  logic [7:0]  i_tag,
    input  logic [2:0]  i_tc,
    input  logic [1:0]  i_attr,
    input  logic [9:0]  i_length,
    input  logic [6:0]  i_addr_lo,
    input  logic        i_ur,
    output logic [31:0] o_dw0,
    output logic [31:0] o_dw1,
    output logic [31:0] o_dw2
);

    cpl_status_t w_status;
    logic [7:0]  w_fmt_type;
    logic [9:0]  w_length;
    logic [11:0] w_byte_count;

    always_comb begin
        w_status     = i_ur ? UR : SC;
        w_fmt_type   = i_ur ? FMT_TYPE_CPL : FMT_TYPE_CPLD;
        w_length     = i_ur ? 10'd0 : i_length;
        // len_dw*4 truncated to 12 bits; length 0 (1024 DW) naturally yields 0.
        w_byte_count = i_ur ? 12'd0 : {i_length, 2'b00};
        o_dw0 = {w_fmt_type, 1'b0, i_tc, 4'h0, 2'b00, i_attr, 2'b00, w_length};
        o_dw1 = {i_completer_id, w_status, 1'b0, w_byte_count};
        o_dw2 = {i_requester_id, i_tag, 1'b0, i_addr_lo};
    end

endmodule

// File: rtl/pcileech_cpl_tx_engine.sv
// Turns accepted memory-read requests into CplD (or UR Cpl) TLPs, fetching payload one DW at a time.
module pcileech_cpl_tx_engine
    import pcileech_tlp_pkg::*;
#(
    parameter int MAX_LEN_DW = 16
)(
    input  logic                             clk,
    input  logic                             reset,
    input  logic [15:0]                      cfg_completer_id,
    pcileech_cpl_tx_engine_if.master         bus,
    output logic                             busy,
    output logic [15:0]                      cpl_count,
    output logic [15:0]                      ur_count
);

    localparam logic [10:0] MAX_LEN = 11'(MAX_LEN_DW);

    cpl_tx_state_t r_state;
    cpl_tx_state_t w_next_state;

    logic        r_rst_done;
    logic [15:0] r_cid;
    logic [15:0] r_rid;
    logic [7:0]  r_tag;
    logic [2:0]  r_tc;
    logic [1:0]  r_attr;
    logic [9:0]  r_len;
    logic [6:0]  r_addr_lo;
    logic        r_ur;
    logic [10:0] r_remain;
    logic [31:0] r_bar_addr;
    logic [31:0] r_data;
    logic [15:0] r_cpl_count;
    logic [15:0] r_ur_count;

    logic        w_accept;
    logic        w_tx_valid;
    logic        w_tx_last;
    logic        w_tx_hs;
    logic [10:0] w_req_len_dw;
    logic        w_req_ur;
    logic [31:0] w_dw0;
    logic [31:0] w_dw1;
    logic [31:0] w_dw2;

    pcileech_cpl_hdr_builder u_hdr (
        .i_completer_id (r_cid),
        .i_requester_id (r_rid),
        .i_tag          (r_tag),
        .i_tc           (r_tc),
        .i_attr         (r_attr),
        .i_length       (r_len),
        .i_addr_lo      (r_addr_lo),
        .i_ur           (r_ur),
        .o_dw0          (w_dw0),
        .o_dw1          (w_dw1),
        .o_dw2          (w_dw2)
    );

    assign w_req_len_dw = len_to_dw(bus.req_length);
    assign w_req_ur     = (w_req_len_dw > MAX_LEN);
    assign w_accept     = bus.req_valid && (r_state == ST_IDLE) && r_rst_done;
    assign w_tx_valid   = (r_state == ST_HDR0) || (r_state == ST_HDR1) ||
                          (r_state == ST_HDR2) || (r_state == ST_SEND);
    assign w_tx_last    = ((r_state == ST_HDR2) && r_ur) ||
                          ((r_state == ST_SEND) && (r_remain == 11'd1));
    assign w_tx_hs      = w_tx_valid && bus.pcie_tx_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next_state = ST_HDR0;
            ST_HDR0:  if (w_tx_hs) w_next_state = ST_HDR1;
            ST_HDR1:  if (w_tx_hs) w_next_state = ST_HDR2;
            ST_HDR2:  if (w_tx_hs) w_next_state = r_ur ? ST_IDLE : ST_FETCH;
            ST_FETCH: w_next_state = ST_WAIT;
            ST_WAIT:  if (bus.bar_rd_valid) w_next_state = ST_SEND;
            ST_SEND:  if (w_tx_hs) w_next_state = (r_remain == 11'd1) ? ST_IDLE : ST_FETCH;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready     = (r_state == ST_IDLE) && r_rst_done;
        bus.bar_rd_en     = (r_state == ST_FETCH);
        bus.bar_addr      = r_bar_addr;
        bus.pcie_tx_valid = w_tx_valid;
        bus.pcie_tx_last  = w_tx_last;
        bus.pcie_tx_data  = 32'd0;
        case (r_state)
            ST_HDR0: bus.pcie_tx_data = w_dw0;
            ST_HDR1: bus.pcie_tx_data = w_dw1;
            ST_HDR2: bus.pcie_tx_data = w_dw2;
            ST_SEND: bus.pcie_tx_data = r_data;
            default: bus.pcie_tx_data = 32'd0;
        endcase
        bus.dbg_state     = r_state;
        busy              = (r_state != ST_IDLE);
        cpl_count         = r_cpl_count;
        ur_count          = r_ur_count;
    end

    // Request fields are latched at accept so the header stays stable through back-pressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rst_done  <= 1'b0;
            r_cid       <= 16'd0;
            r_rid       <= 16'd0;
            r_tag       <= 8'd0;
            r_tc        <= 3'd0;
            r_attr      <= 2'd0;
            r_len       <= 10'd0;
            r_addr_lo   <= 7'd0;
            r_ur        <= 1'b0;
            r_remain    <= 11'd0;
            r_bar_addr  <= 32'd0;
            r_data      <= 32'd0;
            r_cpl_count <= 16'd0;
            r_ur_count  <= 16'd0;
        end else begin
            r_rst_done <= 1'b1;
            if (w_accept) begin
                r_cid      <= cfg_completer_id;
                r_rid      <= bus.req_requester_id;
                r_tag      <= bus.req_tag;
                r_tc       <= bus.req_tc;
                r_attr     <= bus.req_attr;
                r_len      <= bus.req_length;
                r_addr_lo  <= bus.req_addr[6:0];
                r_ur       <= w_req_ur;
                r_remain   <= w_req_len_dw;
                r_bar_addr <= bus.req_addr;
            end
            if ((r_state == ST_WAIT) && bus.bar_rd_valid) begin
                r_data <= bus.bar_rd_data;
            end
            if ((r_state == ST_SEND) && w_tx_hs) begin
                r_bar_addr <= r_bar_addr + 32'd4;
                r_remain   <= r_remain - 11'd1;
            end
            if (w_tx_hs && w_tx_last) begin
                if (r_ur) r_ur_count  <= r_ur_count + 16'd1;
                else      r_cpl_count <= r_cpl_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pcileech_cpl_tx_engine.sv
// Directed bench for the completion TX engine: header/payload words, stalls, UR, slow BAR and reset abort.
module tb_pcileech_cpl_tx_engine;
    import pcileech_tlp_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cfg_completer_id;
    logic        busy;
    logic [15:0] cpl_count;
    logic [15:0] ur_count;

    pcileech_cpl_tx_engine_if bus();

    pcileech_cpl_tx_engine #(.MAX_LEN_DW(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .cfg_completer_id (cfg_completer_id),
        .bus              (bus),
        .busy             (busy),
        .cpl_count        (cpl_count),
        .ur_count         (ur_count)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    bit          got_last_q[$];
    logic [31:0] bar_q[$];
    int          rd_cnt = 0;
    int          bar_lat = 1;
    int          inject_req = 0;
    int          inject_done = 0;
    int          stall_err, wait_valid_err, rdy_in_tlp;
    bit          timeout, req_timeout, dw0_next;
    logic [31:0] rsp_addr;

    function automatic logic [31:0] bar_word(input logic [31:0] a);
        if (a == 32'h0000_1004) return 32'hDEADBEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    // BAR read port: answers each strobe after bar_lat cycles; can also emit one stray valid.
    initial begin
        bus.bar_rd_valid = 1'b0;
        bus.bar_rd_data  = 32'd0;
        forever begin
            @(negedge clk);
            bus.bar_rd_valid = 1'b0;
            if (inject_req != inject_done) begin
                inject_done      = inject_req;
                bus.bar_rd_data  = 32'h0BAD_F00D;
                bus.bar_rd_valid = 1'b1;
            end else if (bus.bar_rd_en && !reset) begin
                rsp_addr = bus.bar_addr;
                rd_cnt++;
                bar_q.push_back(rsp_addr);
                repeat (bar_lat) @(negedge clk);
                if (!reset) begin
                    bus.bar_rd_data  = bar_word(rsp_addr);
                    bus.bar_rd_valid = 1'b1;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_req(input logic [15:0] rid, input logic [7:0] tag, input logic [2:0] tc,
                            input logic [1:0] attr, input logic [9:0] len, input logic [31:0] addr,
                            input bit keep_valid);
        int w = 0;
        @(negedge clk);
        bus.req_requester_id = rid;
        bus.req_tag          = tag;
        bus.req_tc           = tc;
        bus.req_attr         = attr;
        bus.req_length       = len;
        bus.req_addr         = addr;
        bus.req_valid        = 1'b1;
        while (!bus.req_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        req_timeout = (w >= 100);
        @(negedge clk);
        dw0_next = bus.pcie_tx_valid && (bus.dbg_state == ST_HDR0);
        if (!keep_valid) bus.req_valid = 1'b0;
    endtask

    task automatic recv_tlp(input bit toggle, input int budget);
        int          cyc = 0;
        bit          done = 0;
        bit          holding = 0;
        logic [31:0] held_d = 32'd0;
        logic        held_l = 1'b0;
        got_q.delete();
        got_last_q.delete();
        stall_err = 0;
        wait_valid_err = 0;
        rdy_in_tlp = 0;
        while (!done && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (bus.dbg_state == ST_WAIT && bus.pcie_tx_valid) wait_valid_err++;
            if (bus.req_ready) rdy_in_tlp++;
            if (holding && (!bus.pcie_tx_valid || bus.pcie_tx_data !== held_d || bus.pcie_tx_last !== held_l))
                stall_err++;
            bus.pcie_tx_ready = toggle ? cyc[0] : 1'b1;
            if (bus.pcie_tx_valid && bus.pcie_tx_ready) begin
                got_q.push_back(bus.pcie_tx_data);
                got_last_q.push_back(bus.pcie_tx_last);
                holding = 0;
                if (bus.pcie_tx_last) done = 1;
            end else begin
                holding = bus.pcie_tx_valid;
                held_d  = bus.pcie_tx_data;
                held_l  = bus.pcie_tx_last;
            end
        end
        timeout = !done;
        @(negedge clk);
        bus.pcie_tx_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready got=%0b exp=0", bus.req_ready); end
        n_checks++; if (bus.bar_rd_en !== 1'b0 || bus.bar_addr !== 32'd0) begin n_fail++; $display("FAIL rst_bar got en=%0b addr=%08h exp 0/0", bus.bar_rd_en, bus.bar_addr); end
        n_checks++; if (bus.pcie_tx_valid !== 1'b0 || bus.pcie_tx_data !== 32'd0 || bus.pcie_tx_last !== 1'b0) begin n_fail++; $display("FAIL rst_tx got v=%0b d=%08h l=%0b exp 0", bus.pcie_tx_valid, bus.pcie_tx_data, bus.pcie_tx_last); end
        n_checks++; if (busy !== 1'b0 || cpl_count !== 16'd0 || ur_count !== 16'd0) begin n_fail++; $display("FAIL rst_status got busy=%0b cpl=%0d ur=%0d exp 0", busy, cpl_count, ur_count); end
        reset = 1'b0;
        #1;
        n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_release_ready got=%0b exp=0", bus.req_ready); end
        @(negedge clk);
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_first_clk_ready got=%0b exp=1", bus.req_ready); end
    endtask

    task automatic test_1dw();
        exp_q = '{32'h4A000001, 32'h02000004, 32'h01000504, 32'hDEADBEEF};
        send_req(16'h0100, 8'h05, 3'd0, 2'd0, 10'd1, 32'h0000_1004, 1'b0);
        n_checks++; if (req_timeout !== 1'b0 || dw0_next !== 1'b1) begin n_fail++; $display("FAIL 1dw_accept got tmo=%0b dw0_next=%0b exp 0/1", req_timeout, dw0_next); end
        recv_tlp(1'b0, 50);
        n_checks++; if (timeout !== 1'b0 || got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL 1dw_len got tmo=%0b n=%0d exp 0/%0d", timeout, got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i == exp_q.size() - 1)) begin
                n_fail++; $display("FAIL 1dw_dw%0d got=%08h last=%0b exp=%08h last=%0b", i, got_q[i], got_last_q[i], exp_q[i], i == exp_q.size() - 1);
            end
        end
        n_checks++; if (cpl_count !== 16'd1 || ur_count !== 16'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL 1dw_counts got cpl=%0d ur=%0d busy=%0b exp 1/0/0", cpl_count, ur_count, busy); end
        exp_q.delete();
    endtask

    task automatic test_4dw_stall();
        bar_q.delete();
        rd_cnt = 0;
        exp_q = '{32'h4A000004, 32'h02000010, 32'h01000600,
                  32'h2000DFFF, 32'h2004DFFB, 32'h2008DFF7, 32'h200CDFF3};
        send_req(16'h0100, 8'h06, 3'd0, 2'd0, 10'd4, 32'h0000_2000, 1'b0);
        recv_tlp(1'b1, 300);
        n_checks++; if (timeout !== 1'b0 || got_q.size() !== 7) begin n_fail++; $display("FAIL 4dw_handshakes got tmo=%0b n=%0d exp 0/7", timeout, got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i == exp_q.size() - 1)) begin
                n_fail++; $display("FAIL 4dw_dw%0d got=%08h last=%0b exp=%08h last=%0b", i, got_q[i], got_last_q[i], exp_q[i], i == exp_q.size() - 1);
            end
        end
        n_checks++; if (stall_err !== 0) begin n_fail++; $display("FAIL 4dw_stable got=%0d changes exp=0", stall_err); end
        n_checks++; if (rd_cnt !== 4) begin n_fail++; $display("FAIL 4dw_reads got=%0d exp=4", rd_cnt); end
        exp_q = '{32'h0000_2000, 32'h0000_2004, 32'h0000_2008, 32'h0000_200C};
        for (int i = 0; i < 4 && i < bar_q.size(); i++) begin
            n_checks++;
            if (bar_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL 4dw_bar_addr%0d got=%08h exp=%08h", i, bar_q[i], exp_q[i]); end
        end
        n_checks++; if (cpl_count !== 16'd2) begin n_fail++; $display("FAIL 4dw_cpl_count got=%0d exp=2", cpl_count); end
        exp_q.delete();
    endtask

    task automatic test_ur();
        rd_cnt = 0;
        exp_q = '{32'h0A000000, 32'h02002000, 32'h01000744};
        send_req(16'h0100, 8'h07, 3'd0, 2'd0, 10'h020, 32'h0000_4044, 1'b0);
        recv_tlp(1'b0, 50);
        n_checks++; if (timeout !== 1'b0 || got_q.size() !== 3) begin n_fail++; $display("FAIL ur32_len got tmo=%0b n=%0d exp 0/3", timeout, got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i == exp_q.size() - 1)) begin
                n_fail++; $display("FAIL ur32_dw%0d got=%08h last=%0b exp=%08h last=%0b", i, got_q[i], got_last_q[i], exp_q[i], i == exp_q.size() - 1);
            end
        end
        n_checks++; if (rd_cnt !== 0 || ur_count !== 16'd1 || cpl_count !== 16'd2) begin n_fail++; $display("FAIL ur32_side got rd=%0d ur=%0d cpl=%0d exp 0/1/2", rd_cnt, ur_count, cpl_count); end
        // length field 0 means 1024 DW, which is also over the limit
        exp_q = '{32'h0A000000, 32'h02002000, 32'h01000800};
        send_req(16'h0100, 8'h08, 3'd0, 2'd0, 10'd0, 32'h0000_4000, 1'b0);
        recv_tlp(1'b0, 50);
        n_checks++; if (timeout !== 1'b0 || got_q.size() !== 3) begin n_fail++; $display("FAIL ur1024_len got tmo=%0b n=%0d exp 0/3", timeout, got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i == exp_q.size() - 1)) begin
                n_fail++; $display("FAIL ur1024_dw%0d got=%08h last=%0b exp=%08h last=%0b", i, got_q[i], got_last_q[i], exp_q[i], i == exp_q.size() - 1);
            end
        end
        n_checks++; if (rd_cnt !== 0 || ur_count !== 16'd2) begin n_fail++; $display("FAIL ur1024_side got rd=%0d ur=%0d exp 0/2", rd_cnt, ur_count); end
        exp_q.delete();
    endtask

    task automatic test_slow_bar();
        bar_lat = 5;
        exp_q = '{32'h4A502002, 32'h02000008, 32'hABCD3C7C, 32'h107CEF83, 32'h1080EF7F};
        send_req(16'hABCD, 8'h3C, 3'b101, 2'b10, 10'd2, 32'h0000_107C, 1'b0);
        recv_tlp(1'b0, 200);
        bar_lat = 1;
        n_checks++; if (timeout !== 1'b0 || got_q.size() !== 5) begin n_fail++; $display("FAIL slow_len got tmo=%0b n=%0d exp 0/5", timeout, got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i == exp_q.size() - 1)) begin
                n_fail++; $display("FAIL slow_dw%0d got=%08h last=%0b exp=%08h last=%0b", i, got_q[i], got_last_q[i], exp_q[i], i == exp_q.size() - 1);
            end
        end
        n_checks++; if (wait_valid_err !== 0) begin n_fail++; $display("FAIL slow_valid_in_wait got=%0d exp=0", wait_valid_err); end
        n_checks++; if (cpl_count !== 16'd3) begin n_fail++; $display("FAIL slow_cpl_count got=%0d exp=3", cpl_count); end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [15:0] a;
        bar_q.delete();
        exp_q = '{32'h4A000002, 32'h02000008, 32'h0100087C, 32'hFFFC0003, 32'h0000FFFF};
        send_req(16'h0100, 8'h08, 3'd0, 2'd0, 10'd2, 32'hFFFF_FFFC, 1'b1);
        bus.req_tag    = 8'h09;
        bus.req_length = 10'd16;
        bus.req_addr   = 32'h0000_5000;
        recv_tlp(1'b0, 100);
        n_checks++; if (rdy_in_tlp !== 0) begin n_fail++; $display("FAIL b2b_ready_busy got=%0d cycles exp=0", rdy_in_tlp); end
        n_checks++; if (timeout !== 1'b0 || got_q.size() !== 5) begin n_fail++; $display("FAIL b2b_first_len got tmo=%0b n=%0d exp 0/5", timeout, got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i == exp_q.size() - 1)) begin
                n_fail++; $display("FAIL b2b_first_dw%0d got=%08h last=%0b exp=%08h last=%0b", i, got_q[i], got_last_q[i], exp_q[i], i == exp_q.size() - 1);
            end
        end
        n_checks++; if (bar_q.size() < 2 || bar_q[0] !== 32'hFFFF_FFFC || bar_q[1] !== 32'h0000_0000) begin n_fail++; $display("FAIL b2b_addr_wrap got n=%0d exp FFFFFFFC,00000000", bar_q.size()); end
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle_ready got=%0b exp=1", bus.req_ready); end
        @(negedge clk);
        n_checks++; if (bus.dbg_state !== ST_HDR0) begin n_fail++; $display("FAIL b2b_second_accept got state=%0d exp=%0d", bus.dbg_state, ST_HDR0); end
        bus.req_valid = 1'b0;
        exp_q = '{32'h4A000010, 32'h02000040, 32'h01000900};
        for (int i = 0; i < 16; i++) begin
            a = 16'h5000 + 16'(i * 4);
            exp_q.push_back({a, ~a});
        end
        recv_tlp(1'b0, 300);
        n_checks++; if (timeout !== 1'b0 || got_q.size() !== 19) begin n_fail++; $display("FAIL b2b_second_len got tmo=%0b n=%0d exp 0/19", timeout, got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i == exp_q.size() - 1)) begin
                n_fail++; $display("FAIL b2b_second_dw%0d got=%08h last=%0b exp=%08h last=%0b", i, got_q[i], got_last_q[i], exp_q[i], i == exp_q.size() - 1);
            end
        end
        n_checks++; if (cpl_count !== 16'd5 || ur_count !== 16'd2) begin n_fail++; $display("FAIL b2b_counts got cpl=%0d ur=%0d exp 5/2", cpl_count, ur_count); end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_tlp();
        int hs = 0;
        int cyc = 0;
        bit hit = 0;
        send_req(16'h0100, 8'h0A, 3'd0, 2'd0, 10'd2, 32'h0000_3000, 1'b0);
        bus.pcie_tx_ready = 1'b1;
        while (!hit && cyc < 100) begin
            if (bus.dbg_state == ST_SEND && hs == 4) begin
                hit = 1;
            end else begin
                if (bus.pcie_tx_valid && bus.pcie_tx_ready) hs++;
                @(negedge clk);
                cyc++;
            end
        end
        n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL rmid_reach_dw2 got hs=%0d exp=4", hs); end
        reset = 1'b1;
        @(negedge clk);
        bus.pcie_tx_ready = 1'b0;
        n_checks++; if (bus.pcie_tx_valid !== 1'b0 || bus.pcie_tx_data !== 32'd0 || bus.pcie_tx_last !== 1'b0) begin n_fail++; $display("FAIL rmid_tx got v=%0b d=%08h l=%0b exp 0", bus.pcie_tx_valid, bus.pcie_tx_data, bus.pcie_tx_last); end
        n_checks++; if (busy !== 1'b0 || bus.req_ready !== 1'b0 || bus.bar_rd_en !== 1'b0 || bus.bar_addr !== 32'd0) begin n_fail++; $display("FAIL rmid_ctrl got busy=%0b rdy=%0b en=%0b addr=%08h exp 0", busy, bus.req_ready, bus.bar_rd_en, bus.bar_addr); end
        n_checks++; if (cpl_count !== 16'd0 || ur_count !== 16'd0) begin n_fail++; $display("FAIL rmid_counts got cpl=%0d ur=%0d exp 0/0", cpl_count, ur_count); end
        @(negedge clk);
        reset = 1'b0;
        inject_req++;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.dbg_state !== ST_IDLE || bus.pcie_tx_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rmid_stale_valid got state=%0d v=%0b busy=%0b exp IDLE/0/0", bus.dbg_state, bus.pcie_tx_valid, busy); end
        exp_q = '{32'h4A000001, 32'h02000004, 32'h01000504, 32'hDEADBEEF};
        send_req(16'h0100, 8'h05, 3'd0, 2'd0, 10'd1, 32'h0000_1004, 1'b0);
        recv_tlp(1'b0, 50);
        n_checks++; if (timeout !== 1'b0 || got_q.size() !== 4) begin n_fail++; $display("FAIL rmid_after_len got tmo=%0b n=%0d exp 0/4", timeout, got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i == exp_q.size() - 1)) begin
                n_fail++; $display("FAIL rmid_after_dw%0d got=%08h last=%0b exp=%08h last=%0b", i, got_q[i], got_last_q[i], exp_q[i], i == exp_q.size() - 1);
            end
        end
        n_checks++; if (cpl_count !== 16'd1) begin n_fail++; $display("FAIL rmid_after_cpl_count got=%0d exp=1", cpl_count); end
        exp_q.delete();
    endtask

    initial begin
        reset                = 1'b1;
        cfg_completer_id     = 16'h0200;
        bus.req_valid        = 1'b0;
        bus.req_requester_id = 16'd0;
        bus.req_tag          = 8'd0;
        bus.req_tc           = 3'd0;
        bus.req_attr         = 2'd0;
        bus.req_length       = 10'd0;
        bus.req_addr         = 32'd0;
        bus.pcie_tx_ready    = 1'b0;

        test_reset();
        test_1dw();
        test_4dw_stall();
        test_ur();
        test_slow_bar();
        test_back_to_back();
        test_reset_mid_tlp();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
